// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file for the pipelined MIPS core.
// Two combinational read ports with same-cycle write-through bypass, plus a retired-write counter.
module wb_regfile #(
   parameter logic [31:0] SP_RESET = 32'h0000_0000,
   parameter logic [31:0] GP_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WB_RegWrite,
   input  logic [1:0]  WB_MemtoReg,
   input  logic [31:0] WB_ReadData,
   input  logic [31:0] WB_WriteAddress,
   input  logic [31:0] WB_ALUout,
   input  logic [31:0] WB_PCjia4,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   output logic [31:0] ID_rsData,
   output logic [31:0] ID_rtData,
   output logic [31:0] WB_WriteData,
   output logic        WB_WriteEn,
   output logic [31:0] wb_count
);

   logic [31:0] regs_r [0:31];
   logic [31:0] wb_count_r;
   logic [4:0]  waddr_s;
   logic [31:0] wdata_s;
   logic        wen_s;
   logic [31:0] rs_data_s;
   logic [31:0] rt_data_s;
   logic        unused_addr_s;

   assign waddr_s       = WB_WriteAddress[4:0];
   assign unused_addr_s = ^WB_WriteAddress[31:5];

   // Write-back source select; the reserved encoding falls back to the ALU result.
   always_comb begin
      wdata_s = WB_ALUout;
      case (WB_MemtoReg)
         2'b01:   wdata_s = WB_ReadData;
         2'b10:   wdata_s = WB_PCjia4;
         default: wdata_s = WB_ALUout;
      endcase
   end

   // Effective write enable: writes aimed at $0 are dropped before they reach the array.
   always_comb begin
      if (WB_RegWrite && (waddr_s != 5'd0)) begin
         wen_s = 1'b1;
      end else begin
         wen_s = 1'b0;
      end
   end

   // Read port A: $0 is hardwired, then bypass of the in-flight write, then the array.
   always_comb begin
      rs_data_s = 32'h0000_0000;
      if (ID_rs == 5'd0) begin
         rs_data_s = 32'h0000_0000;
      end else if (wen_s && (ID_rs == waddr_s)) begin
         rs_data_s = wdata_s;
      end else begin
         rs_data_s = regs_r[ID_rs];
      end
   end

   // Read port B: same priority as port A, bypassing independently.
   always_comb begin
      rt_data_s = 32'h0000_0000;
      if (ID_rt == 5'd0) begin
         rt_data_s = 32'h0000_0000;
      end else if (wen_s && (ID_rt == waddr_s)) begin
         rt_data_s = wdata_s;
      end else begin
         rt_data_s = regs_r[ID_rt];
      end
   end

   // Array commit and retired-write counter; reset wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
         regs_r[28] <= GP_RESET;
         regs_r[29] <= SP_RESET;
         wb_count_r <= 32'h0000_0000;
      end else if (wen_s) begin
         regs_r[waddr_s] <= wdata_s;
         wb_count_r      <= wb_count_r + 32'd1;
      end else begin
         wb_count_r <= wb_count_r;
      end
   end

   assign ID_rsData    = rs_data_s;
   assign ID_rtData    = rt_data_s;
   assign WB_WriteData = wdata_s;
   assign WB_WriteEn   = wen_s;
   assign wb_count     = wb_count_r;

endmodule
